// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types and constants for the two-master RAM arbiter
package bus_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   typedef logic master_idx_t;

   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

   // Timeout counter width: wide enough for the limit, kept within 8..32 bits
   function automatic int unsigned cnt_width(input int unsigned cycles);
      int unsigned w;
      if (cycles > 32'h7FFF_FFFF) return 32;
      w = $clog2(cycles + 1);
      if (w < 8) w = 8;
      if (w > 32) w = 32;
      return w;
   endfunction

endpackage

// File: rtl/bus_if.sv
// rtl/bus_if.sv - valid/ready request/response bus between masters, arbiter and RAM
interface bus_if #(
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  valid;
   logic                  ready;
   logic [ADDR_WIDTH-1:0] addr;
   logic [3:0]            wstrb;
   logic [31:0]           write_data;
   logic [31:0]           read_data;

   modport master (output valid, addr, wstrb, write_data, input ready, read_data);
   modport slave  (input valid, addr, wstrb, write_data, output ready, read_data);
endinterface

// File: rtl/bus_arbiter_rr_pick2.sv
// rtl/bus_arbiter_rr_pick2.sv - two-way round-robin chooser; on a tie the master other than last wins
module rr_pick2
   import bus_arbiter_pkg::*;
(
   input  logic [1:0]  req,
   input  master_idx_t last,
   output logic [1:0]  gnt
);

   assign gnt[0] = req[0] & (~req[1] | (last == 1'b1));
   assign gnt[1] = req[1] & (~req[0] | (last == 1'b0));

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master, one-slave whole-transaction arbiter in front of the block RAM
// Optional forced completion of stalled transactions: define BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned ADDR_WIDTH     = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   bus_if.slave        m0_bus,
   bus_if.slave        m1_bus,
   bus_if.master       mem_bus,
   output logic [1:0]  grant_o,
   output logic        timeout_o
);

   arb_state_e            state;
   master_idx_t           last_grant;
   logic [1:0]            pick;
   logic                  busy;
   logic                  done;
   logic                  to_hit;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [31:0]           rdata;

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("bus_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   rr_pick2 u_pick (
      .req  ({m1_bus.valid, m0_bus.valid}),
      .last (last_grant),
      .gnt  (pick)
   );

`ifdef BUS_ARBITER_TIMEOUT_EN
   localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] to_cnt;

   // A real ready in the limit cycle takes priority over the forced completion
   assign to_hit = busy && !mem_bus.ready && (to_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
   assign to_hit = 1'b0;
`endif

   assign busy      = (state == BUSY);
   assign done      = busy && (mem_bus.ready || to_hit);
   assign timeout_o = to_hit;

   assign sel_addr           = grant_o[1] ? m1_bus.addr : m0_bus.addr;
   assign mem_bus.valid      = busy;
   assign mem_bus.addr       = sel_addr;
   assign mem_bus.wstrb      = grant_o[1] ? m1_bus.wstrb : m0_bus.wstrb;
   assign mem_bus.write_data = grant_o[1] ? m1_bus.write_data : m0_bus.write_data;

   assign rdata = to_hit ? TIMEOUT_RDATA : mem_bus.read_data;

   assign m0_bus.ready     = done && grant_o[0];
   assign m1_bus.ready     = done && grant_o[1];
   assign m0_bus.read_data = (busy && grant_o[0]) ? rdata : 32'h0;
   assign m1_bus.read_data = (busy && grant_o[1]) ? rdata : 32'h0;

   // Completion always returns to IDLE, giving the RAM its dead cycle before the next grant
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         grant_o    <= 2'b00;
         last_grant <= 1'b1;
`ifdef BUS_ARBITER_TIMEOUT_EN
         to_cnt     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pick != 2'b00) begin
                  state      <= BUSY;
                  grant_o    <= pick;
                  last_grant <= pick[1];
`ifdef BUS_ARBITER_TIMEOUT_EN
                  to_cnt     <= '0;
`endif
               end
            end
            BUSY: begin
               if (done) begin
                  state   <= IDLE;
                  grant_o <= 2'b00;
               end
`ifdef BUS_ARBITER_TIMEOUT_EN
               else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed vector bench for bus_arbiter with a one-wait-state RAM model
module tb_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] grant;
   logic       timeout;
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   bus_if #(.ADDR_WIDTH(32)) m0_if ();
   bus_if #(.ADDR_WIDTH(32)) m1_if ();
   bus_if #(.ADDR_WIDTH(32)) mem_if ();

   bus_arbiter #(.TIMEOUT_CYCLES(4), .ADDR_WIDTH(32)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .m0_bus    (m0_if),
      .m1_bus    (m1_if),
      .mem_bus   (mem_if),
      .grant_o   (grant),
      .timeout_o (timeout)
   );

   logic [31:0] ram [0:255];
   logic        ram_ready_q = 1'b0;
   logic [31:0] ram_rdata = 32'h0;
   logic        ram_clear = 1'b1;
   logic        ram_stall = 1'b0;
   logic        spur_ready = 1'b0;

   assign mem_if.ready     = ram_ready_q | spur_ready;
   assign mem_if.read_data = ram_rdata;

   always @(posedge clk) begin
      if (ram_clear) begin
         for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
         ram[4]      <= 32'hCAFE_0001;
         ram_ready_q <= 1'b0;
      end else if (mem_if.valid && !ram_ready_q && !ram_stall) begin
         ram_ready_q <= 1'b1;
         ram_rdata   <= ram[mem_if.addr[9:2]];
         for (int b = 0; b < 4; b++)
            if (mem_if.wstrb[b]) ram[mem_if.addr[9:2]][8*b +: 8] <= mem_if.write_data[8*b +: 8];
      end else begin
         ram_ready_q <= 1'b0;
      end
   end

   typedef struct {
      bit          m;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      bit          chk_rd;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_master(input bit m, input bit v, input logic [31:0] a,
                             input logic [3:0] s, input logic [31:0] d);
      if (m) begin
         m1_if.valid = v; m1_if.addr = a; m1_if.wstrb = s; m1_if.write_data = d;
      end else begin
         m0_if.valid = v; m0_if.addr = a; m0_if.wstrb = s; m0_if.write_data = d;
      end
   endtask

   function automatic logic rdy(input bit m);
      return m ? m1_if.ready : m0_if.ready;
   endfunction

   function automatic logic [31:0] rdd(input bit m);
      return m ? m1_if.read_data : m0_if.read_data;
   endfunction

   // One transaction: valid raised in cycle N, lat counts negedges from N to the ready
   task automatic do_txn(input bit m, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input int budget,
                         output int lat, output logic [31:0] rd, output logic [1:0] g1,
                         output bit other_rdy, output bit to_seen);
      lat = -1; rd = 32'h0; g1 = 2'b00; other_rdy = 1'b0; to_seen = 1'b0;
      @(posedge clk); #1;
      set_master(m, 1'b1, a, s, d);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (c == 1) g1 = grant;
         if (rdy(!m)) other_rdy = 1'b1;
         if (rdy(m)) begin
            lat = c; rd = rdd(m); to_seen = timeout;
            break;
         end
      end
      @(posedge clk); #1;
      set_master(m, 1'b0, a, 4'h0, 32'h0);
   endtask

   int          lat;
   logic [31:0] rd;
   logic [1:0]  g1;
   bit          other_rdy;
   bit          to_seen;
   int          ev;
   int          ev_m [4];
   int          ev_t [4];
   logic [1:0]  ev_g [4];
   int          m1_done;
   bit          m0_seen;
   bit          got_grant;

   initial begin
      vecs[0] = '{1'b0, 32'h10, 4'b0000, 32'h0,          1'b1, 32'hCAFE_0001};
      vecs[1] = '{1'b1, 32'h20, 4'b0011, 32'h1122_3344,  1'b0, 32'h0};
      vecs[2] = '{1'b1, 32'h20, 4'b0000, 32'h0,          1'b1, 32'h0000_3344};
      vecs[3] = '{1'b0, 32'h24, 4'b1111, 32'hAABB_CCDD,  1'b0, 32'h0};
      vecs[4] = '{1'b1, 32'h24, 4'b0000, 32'h0,          1'b1, 32'hAABB_CCDD};
      vecs[5] = '{1'b0, 32'h24, 4'b1000, 32'h0000_0055,  1'b0, 32'h0};
      vecs[6] = '{1'b1, 32'h24, 4'b0000, 32'h0,          1'b1, 32'h00BB_CCDD};

      set_master(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      set_master(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset grant_o", {30'h0, grant}, 32'h0);
      check("reset timeout_o", {31'h0, timeout}, 32'h0);
      check("reset mem valid", {31'h0, mem_if.valid}, 32'h0);
      check("reset m0 ready", {31'h0, m0_if.ready}, 32'h0);
      check("reset m1 ready", {31'h0, m1_if.ready}, 32'h0);
      rst = 1'b0;
      ram_clear = 1'b0;

      for (int i = 0; i < 7; i++) begin
         do_txn(vecs[i].m, vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, 10, lat, rd, g1, other_rdy, to_seen);
         check($sformatf("vec%0d latency", i), lat, 32'd2);
         check($sformatf("vec%0d grant_o", i), {30'h0, g1}, vecs[i].m ? 32'd2 : 32'd1);
         check($sformatf("vec%0d other ready", i), {31'h0, other_rdy}, 32'h0);
         if (vecs[i].chk_rd) check($sformatf("vec%0d read_data", i), rd, vecs[i].exp_rd);
      end

      // Spurious slave ready while idle must not reach either master
      @(posedge clk); #1;
      spur_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("spurious m0 ready", {31'h0, m0_if.ready}, 32'h0);
         check("spurious m1 ready", {31'h0, m1_if.ready}, 32'h0);
         check("spurious grant_o", {30'h0, grant}, 32'h0);
      end
      @(posedge clk); #1;
      spur_ready = 1'b0;

      // Contention: both held, strict alternation starting with m0
      for (int k = 0; k < 4; k++) begin ev_m[k] = -1; ev_t[k] = -1; ev_g[k] = 2'b00; end
      ev = 0;
      @(posedge clk); #1;
      set_master(1'b0, 1'b1, 32'h10, 4'h0, 32'h0);
      set_master(1'b1, 1'b1, 32'h20, 4'h0, 32'h0);
      for (int c = 0; c < 30 && ev < 4; c++) begin
         @(negedge clk);
         if (m0_if.ready || m1_if.ready) begin
            ev_m[ev] = m1_if.ready ? 1 : 0; ev_t[ev] = c; ev_g[ev] = grant; ev++;
         end
      end
      @(posedge clk); #1;
      set_master(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      set_master(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
      check("contention ready count", ev, 32'd4);
      check("contention first latency", ev_t[0], 32'd2);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("contention order %0d", k), ev_m[k], (k % 2 == 0) ? 32'd0 : 32'd1);
         check($sformatf("contention grant %0d", k), {30'h0, ev_g[k]}, (k % 2 == 0) ? 32'd1 : 32'd2);
         if (k > 0) check($sformatf("contention spacing %0d", k), ev_t[k] - ev_t[k-1], 32'd3);
      end

      // Stuck request: m1 hammers, m0 asks once and must follow one m1 transaction
      @(posedge clk); #1;
      set_master(1'b1, 1'b1, 32'h20, 4'h0, 32'h0);
      got_grant = 1'b0;
      for (int c = 0; c < 10 && !got_grant; c++) begin
         @(negedge clk);
         if (grant == 2'b10) got_grant = 1'b1;
      end
      check("stuck m1 granted", {31'h0, got_grant}, 32'h1);
      set_master(1'b0, 1'b1, 32'h10, 4'h0, 32'h0);
      m1_done = 0;
      m0_seen = 1'b0;
      for (int c = 0; c < 20 && !m0_seen; c++) begin
         if (c > 0) @(negedge clk);
         if (m1_if.ready) m1_done++;
         if (m0_if.ready) begin
            m0_seen = 1'b1;
            check("stuck m0 read_data", m0_if.read_data, 32'hCAFE_0001);
         end
      end
      @(posedge clk); #1;
      set_master(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      set_master(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
      check("stuck m0 served", {31'h0, m0_seen}, 32'h1);
      check("stuck m1 before m0", m1_done, 32'd1);

      // Reset one cycle after the m0 grant
      @(posedge clk); #1;
      set_master(1'b0, 1'b1, 32'h10, 4'h0, 32'h0);
      @(posedge clk); @(posedge clk); #1;
      check("midbusy grant before reset", {30'h0, grant}, 32'd1);
      check("midbusy mem valid before reset", {31'h0, mem_if.valid}, 32'h1);
      #2 rst = 1'b1;
      #1;
      check("midbusy mem valid in reset", {31'h0, mem_if.valid}, 32'h0);
      check("midbusy m0 ready in reset", {31'h0, m0_if.ready}, 32'h0);
      check("midbusy grant in reset", {30'h0, grant}, 32'h0);
      set_master(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post reset m0 ready", {31'h0, m0_if.ready}, 32'h0);
      do_txn(1'b0, 32'h10, 4'h0, 32'h0, 10, lat, rd, g1, other_rdy, to_seen);
      check("post reset latency", lat, 32'd2);
      check("post reset read_data", rd, 32'hCAFE_0001);

      // Stalled slave
      ram_stall = 1'b1;
      do_txn(1'b0, 32'h10, 4'h0, 32'h0, 12, lat, rd, g1, other_rdy, to_seen);
`ifdef BUS_ARBITER_TIMEOUT_EN
      check("timeout latency", lat, 32'd5);
      check("timeout read_data", rd, 32'hDEAD_BEEF);
      check("timeout pulse", {31'h0, to_seen}, 32'h1);
      @(negedge clk);
      check("timeout pulse ends", {31'h0, timeout}, 32'h0);
`else
      check("stall no ready", lat, 32'hFFFF_FFFF);
      check("stall no timeout", {31'h0, timeout}, 32'h0);
      check("stall still busy", {31'h0, mem_if.valid}, 32'h1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
`endif
      ram_stall = 1'b0;
      do_txn(1'b1, 32'h20, 4'h0, 32'h0, 10, lat, rd, g1, other_rdy, to_seen);
      check("after stall latency", lat, 32'd2);
      check("after stall read_data", rd, 32'h0000_3344);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter placed directly upstream of the block RAM on the data bus.
- Master 0 is the instruction fetch path; master 1 is the load/store path. Both share one single-port RAM.
- Grants one whole transaction at a time, round-robin on ties, and returns ready and read_data only to the granted master.

Parameters:
- TIMEOUT_CYCLES, 255: cycles a granted transaction may wait for the slave's ready before forced completion. Used only with the optional feature.
- ADDR_WIDTH, 32: width of the addr field forwarded to the slave.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- m0_bus  bus_if.slave  intf  master 0 request/response (valid, ready, addr, wstrb, write_data, read_data).
- m1_bus  bus_if.slave  intf  master 1 request/response.
- mem_bus  bus_if.master  intf  to the RAM slave.
- grant_o  out  2  one-hot current grant, for debug/perf counters.
- timeout_o  out  1  one-cycle pulse when a transaction is force-completed. Tied 0 when the optional feature is off.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, grant_o=2'b00, last_grant=1 (so master 0 wins the first tie), mem_bus.valid=0, both master ready=0, timeout_o=0.
- State IDLE:
  - Sample m0_bus.valid and m1_bus.valid.
  - Only one valid: grant that master.
  - Both valid: grant the master not equal to last_grant.
  - Any grant: register grant_o, update last_grant, go to BUSY.
  - Neither valid: stay in IDLE.
- State BUSY:
  - mem_bus.valid=1.
  - mem_bus addr, wstrb and write_data are combinational muxes of the granted master. Masters hold these stable until they see ready.
  - When mem_bus.ready=1: the granted master's ready=1 in the same cycle (combinational pass-through). Its read_data is mem_bus.read_data. Next state IDLE, grant_o cleared.
- Ungranted master: ready=0 always. Its read_data is driven 0.
- Handshake rules:
  - A master deasserts valid, or presents a new request, in the cycle after its ready.
  - The arbiter never re-grants in the same cycle ready is seen. The mandatory IDLE cycle covers the RAM's dead cycle after each ready.
- Latency, single master, RAM slave: valid at cycle N → mem_bus.valid at N+1 → ready at N+2. Back-to-back throughput is one transaction per 3 cycles.
- Contention: alternates strictly. A continuously requesting master waits at most one foreign transaction.
- Requests are never dropped or duplicated. A master's valid seen in IDLE but not granted stays pending until granted.
- Write vs read is irrelevant to arbitration: wstrb=0 is a read, any bit set is a write.
- Reset mid-BUSY: immediate return to IDLE, mem_bus.valid drops asynchronously, no ready is issued. The in-flight RAM write may or may not have landed.
- Spurious mem_bus.ready in IDLE: ignored, not forwarded.

Optional Feature:
- Macro: BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - An 8..32-bit counter clears on entering BUSY and increments each BUSY cycle without ready.
  - When the count reaches TIMEOUT_CYCLES: force completion. Granted master ready=1 and read_data=32'hDEAD_BEEF for one cycle, timeout_o pulses, state goes to IDLE.
  - Ready and timeout in the same cycle: ready wins, no timeout pulse.
- Undefined: no counter is present, timeout_o=0, and BUSY waits indefinitely.

Decomposition:
- Package bus_arbiter_pkg holds:
  - arb_state_e enum {IDLE, BUSY};
  - master_idx_t (1-bit);
  - TIMEOUT_RDATA constant 32'hDEAD_BEEF.
- One sub-module, rr_pick2: pure 2-way round-robin chooser. Inputs req[1:0] and last; output one-hot gnt. Instantiated once in IDLE decode.

Test Plan:
- Reset then m0 read addr 0x10 (RAM preloaded 0x10→0xCAFE0001) → m0 ready at cycle N+2, read_data=0xCAFE0001, m1 ready stays 0.
- m1 write addr 0x20 data 0x11223344 wstrb 4'b0011, then m1 read 0x20 → read returns 0x00003344 (RAM zero-initialised).
- m0 and m1 valid in the same cycle, both held → grant order m0, m1, m0, m1. grant_o sequence 01, 10, 01, 10. Each ready 3 cycles apart.
- Assert rst_i mid-BUSY (one cycle after m0 grant) → mem_bus.valid=0 the same cycle, no ready to m0. After release, m0 re-request completes normally.
- With BUS_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave ready tied 0 → m0 ready and timeout_o pulse after 4 BUSY cycles, read_data=0xDEADBEEF. Without the macro, no ready ever.
- Stuck-request check: m1 requests every cycle while m0 requests once → m0 granted no later than after one m1 transaction.
